cpu_run_controller: RTL and testbench

- Parametrised run/dump harness for the PipelinedCPU; next generation of the lab test bench flow, but synthesizable.
- Sequences CPU reset, runs until halt or a cycle timeout, then settles.
- Streams the register file and data memory out over a valid/ready dump port.
- Sits between the CPU (and its RF/DMEM read ports) and the bench or host logic.

---
 rtl/cpu_harness_pkg.sv | 26 ++
 rtl/dump_sequencer.sv | 70 +++++++
 rtl/cpu_run_controller.sv | 133 +++++++++++++
 tb/tb_cpu_run_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_harness_pkg.sv
// Shared state encoding, dump-kind tags and default sizing for the CPU run/dump harness.
package cpu_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RESET    = 3'd1,
    ST_RUN      = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DUMP_RF  = 3'd4,
    ST_DUMP_MEM = 3'd5,
    ST_DONE     = 3'd6
  } run_state_t;

  localparam logic DUMP_KIND_REG = 1'b0;
  localparam logic DUMP_KIND_MEM = 1'b1;

  localparam int DEF_RESET_CYCLES   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1000;
  localparam int DEF_DRAIN_CYCLES   = 2;
  localparam int DEF_REG_COUNT      = 32;
  localparam int DEF_MEM_WORDS      = 1024;
  localparam int DEF_ADDR_W         = 10;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_CYC_W          = 32;

endpackage

// File: rtl/dump_sequencer.sv
// Streams RF then DMEM words over valid/ready; data is a combinational pass-through of the read ports.
// One word per cycle with ready high; index, kind and data hold while valid & !ready.
module dump_sequencer import cpu_harness_pkg::*; #(
  parameter int REG_COUNT = DEF_REG_COUNT,
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  localparam int RF_AW    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_dump,
  output logic              rf_done,
  output logic              dump_done,
  output logic [RF_AW-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_kind,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data
);

  logic              active;
  logic              kind;
  logic [ADDR_W-1:0] index;
  logic              accept;
  logic              last_rf;
  logic              last_mem;

  assign accept   = active & dump_ready;
  assign last_rf  = (kind == DUMP_KIND_REG) && (index == ADDR_W'(REG_COUNT - 1));
  assign last_mem = (kind == DUMP_KIND_MEM) && (index == ADDR_W'(MEM_WORDS - 1));
  assign rf_done   = accept & last_rf;
  assign dump_done = accept & last_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      kind   <= DUMP_KIND_REG;
      index  <= '0;
    end else if (start_dump) begin
      active <= 1'b1;
      kind   <= DUMP_KIND_REG;
      index  <= '0;
    end else if (accept) begin
      if (last_rf) begin
        kind  <= DUMP_KIND_MEM;
        index <= '0;
      end else if (last_mem) begin
        active <= 1'b0;
        kind   <= DUMP_KIND_REG;
        index  <= '0;
      end else begin
        index <= index + ADDR_W'(1);
      end
    end
  end

  // Only the read port of the active phase sees the index; the other is parked at 0.
  assign rf_rd_addr  = (kind == DUMP_KIND_REG) ? index[RF_AW-1:0] : '0;
  assign mem_rd_addr = (kind == DUMP_KIND_MEM) ? index : '0;
  assign dump_valid  = active;
  assign dump_kind   = kind;
  assign dump_index  = index;
  assign dump_data   = (kind == DUMP_KIND_MEM) ? mem_rd_data : rf_rd_data;

endmodule

// File: rtl/cpu_run_controller.sv
// Sequences CPU reset, run until halt/timeout, drain, then RF+DMEM dump; control outputs registered.
// Dump stalls on !dump_ready; start is honoured only in IDLE or DONE.
module cpu_run_controller import cpu_harness_pkg::*; #(
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int REG_COUNT      = DEF_REG_COUNT,
  parameter int MEM_WORDS      = DEF_MEM_WORDS,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int CYC_W          = DEF_CYC_W,
  localparam int RF_AW         = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              cpu_rst,
  output logic              cpu_clk_en,
  input  logic              cpu_halt,
  output logic [RF_AW-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_kind,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              done,
  output logic              timed_out,
  output logic [CYC_W-1:0]  cycle_count
);

  run_state_t       state, state_nxt;
  logic [CYC_W-1:0] phase, phase_nxt;
  logic [CYC_W-1:0] cyc_nxt, cyc_inc;
  logic             to_nxt;
  logic             start_dump;
  logic             rf_done;
  logic             dump_done;

  assign cyc_inc = cycle_count + CYC_W'(1);

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    cyc_nxt    = cycle_count;
    to_nxt     = timed_out;
    start_dump = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_RESET;
          phase_nxt = CYC_W'(RESET_CYCLES - 1);
          cyc_nxt   = '0;
          to_nxt    = 1'b0;
        end
      end
      ST_RESET: begin
        if (phase == '0) state_nxt = ST_RUN;
        else             phase_nxt = phase - CYC_W'(1);
      end
      ST_RUN: begin
        // Halt takes priority, so a halt on the timeout cycle is not counted.
        if (cpu_halt) begin
          state_nxt = ST_DRAIN;
          phase_nxt = CYC_W'(DRAIN_CYCLES - 1);
        end else begin
          cyc_nxt = cyc_inc;
          if (cyc_inc == CYC_W'(TIMEOUT_CYCLES)) begin
            to_nxt    = 1'b1;
            state_nxt = ST_DRAIN;
            phase_nxt = CYC_W'(DRAIN_CYCLES - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (phase == '0) begin
          state_nxt  = ST_DUMP_RF;
          start_dump = 1'b1;
        end else begin
          phase_nxt = phase - CYC_W'(1);
        end
      end
      ST_DUMP_RF:  if (rf_done)   state_nxt = ST_DUMP_MEM;
      ST_DUMP_MEM: if (dump_done) state_nxt = ST_DONE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      phase       <= '0;
      cycle_count <= '0;
      timed_out   <= 1'b0;
      cpu_rst     <= 1'b0;
      cpu_clk_en  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      cycle_count <= cyc_nxt;
      timed_out   <= to_nxt;
      cpu_rst     <= !(state_nxt inside {ST_IDLE, ST_RESET});
      cpu_clk_en  <= (state_nxt inside {ST_RESET, ST_RUN});
      done        <= (state_nxt == ST_DONE);
    end
  end

  dump_sequencer #(
    .REG_COUNT (REG_COUNT),
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) u_dump_sequencer (
    .clk         (clk),
    .rst         (rst),
    .start_dump  (start_dump),
    .rf_done     (rf_done),
    .dump_done   (dump_done),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_kind   (dump_kind),
    .dump_index  (dump_index),
    .dump_data   (dump_data)
  );

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: halt, timeout, coincident halt/timeout, backpressure, async reset.
module tb_cpu_run_controller;

  localparam int RC   = 4;
  localparam int TO   = 20;
  localparam int DR   = 2;
  localparam int NREG = 32;
  localparam int NMEM = 16;
  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int CW   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, cpu_halt, dump_ready;
  logic          cpu_rst, cpu_clk_en, dump_valid, dump_kind, done, timed_out;
  logic [4:0]    rf_rd_addr;
  logic [AW-1:0] mem_rd_addr, dump_index;
  logic [DW-1:0] rf_rd_data, mem_rd_data, dump_data;
  logic [CW-1:0] cycle_count;

  logic [DW-1:0] rf_m [NREG];
  logic [DW-1:0] dm_m [64];

  int total = 0;
  int bad   = 0;

  function automatic logic [DW-1:0] rf_val(input int i);
    return 32'hA500_0000 + 32'(i * 3);
  endfunction

  function automatic logic [DW-1:0] dm_val(input int i);
    return 32'hD000_0000 ^ 32'(i * 7 + 1);
  endfunction

  assign rf_rd_data  = rf_m[rf_rd_addr];
  assign mem_rd_data = dm_m[mem_rd_addr];

  cpu_run_controller #(
    .RESET_CYCLES   (RC),
    .TIMEOUT_CYCLES (TO),
    .DRAIN_CYCLES   (DR),
    .REG_COUNT      (NREG),
    .MEM_WORDS      (NMEM),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .CYC_W          (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cpu_rst     (cpu_rst),
    .cpu_clk_en  (cpu_clk_en),
    .cpu_halt    (cpu_halt),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_kind   (dump_kind),
    .dump_index  (dump_index),
    .dump_data   (dump_data),
    .done        (done),
    .timed_out   (timed_out),
    .cycle_count (cycle_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One start-to-DONE sequence. halt_at = RUN cycle on which halt is raised (0 = never).
  task automatic do_run(input int halt_at, input bit rnd, input int exp_cyc, input bit exp_to,
                        input int exp_run, input bit start_mid, input bit abort7);
    int n_rst, n_run, n_drain, got, first_v, done_at;
    bit halt_pend, prev_stall, fin;
    logic [63:0] held, expw;
    n_rst = 0; n_run = 0; n_drain = 0; got = 0; first_v = -1; done_at = -1;
    halt_pend = 1'b0; prev_stall = 1'b0; fin = 1'b0; held = '0; expw = '0;

    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("start_done_clr", 64'(done), 64'd0);
    chk("start_to_clr", 64'(timed_out), 64'd0);
    chk("start_cyc_clr", 64'(cycle_count), 64'd0);
    chk("start_enter_reset", 64'({cpu_rst, cpu_clk_en}), 64'b01);
    n_rst = 1;

    for (int it = 1; it < 400 && !fin; it++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (halt_pend) begin
        chk("clk_en_drop", 64'({cpu_rst, cpu_clk_en}), 64'b10);
        halt_pend = 1'b0;
      end
      if (prev_stall)
        chk("stall_hold", 64'({dump_valid, dump_kind, dump_index, dump_data}), held);
      if (done) begin
        done_at = it;
        fin = 1'b1;
      end else if (!cpu_rst && cpu_clk_en) begin
        n_rst++;
      end else if (cpu_rst && cpu_clk_en) begin
        n_run++;
        if (n_run == halt_at) begin
          cpu_halt  = 1'b1;
          halt_pend = 1'b1;
        end
        if (start_mid && n_run == 3) start = 1'b1;
      end else if (cpu_rst && !dump_valid) begin
        n_drain++;
      end

      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dump_valid) begin
        if (first_v < 0) first_v = it;
        if (abort7 && dump_kind && dump_index == AW'(7)) begin
          chk("abort_words_before", 64'(got), 64'(NREG + 7));
          #2 rst = 1'b0;
          #1;
          chk("arst_valid", 64'(dump_valid), 64'd0);
          chk("arst_cpu", 64'({cpu_rst, cpu_clk_en}), 64'd0);
          chk("arst_done_to", 64'({done, timed_out}), 64'd0);
          chk("arst_cyc", 64'(cycle_count), 64'd0);
          chk("arst_addr", 64'({mem_rd_addr, dump_index, rf_rd_addr}), 64'd0);
          @(posedge clk); #1;
          rst = 1'b1; cpu_halt = 1'b0; dump_ready = 1'b0;
          return;
        end
        if (dump_ready) begin
          if (got < NREG) expw = 64'({1'b0, AW'(got), rf_val(got)});
          else            expw = 64'({1'b1, AW'(got - NREG), dm_val(got - NREG)});
          chk("dump_word", 64'({dump_kind, dump_index, dump_data}), expw);
          got++;
        end
      end
      prev_stall = dump_valid && !dump_ready;
      held = 64'({dump_valid, dump_kind, dump_index, dump_data});
    end

    cpu_halt = 1'b0;
    dump_ready = 1'b0;
    chk("reset_cycles", 64'(n_rst), 64'(RC));
    chk("run_cycles", 64'(n_run), 64'(exp_run));
    chk("drain_cycles", 64'(n_drain), 64'(DR));
    chk("cycle_count", 64'(cycle_count), 64'(exp_cyc));
    chk("timed_out", 64'(timed_out), 64'(exp_to));
    chk("words_accepted", 64'(got), 64'(NREG + NMEM));
    chk("done", 64'(done), 64'd1);
    if (!rnd) chk("no_gap", 64'(done_at - first_v), 64'(NREG + NMEM));
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) rf_m[i] = rf_val(i);
    for (int i = 0; i < 64; i++)   dm_m[i] = dm_val(i);
    rst = 1'b0; start = 1'b0; cpu_halt = 1'b0; dump_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu", 64'({cpu_rst, cpu_clk_en}), 64'd0);
    chk("rst_valid_done_to", 64'({dump_valid, done, timed_out}), 64'd0);
    chk("rst_cyc", 64'(cycle_count), 64'd0);
    chk("rst_addr", 64'({rf_rd_addr, mem_rd_addr, dump_index}), 64'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", 64'({cpu_rst, cpu_clk_en, done}), 64'd0);

    // Normal halt on the 11th RUN cycle.
    do_run(11, 1'b0, 10, 1'b0, 11, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", 64'({done, dump_valid, cpu_rst, cpu_clk_en}), 64'b1010);
    chk("done_cyc_hold", 64'(cycle_count), 64'd10);

    // Timeout, then halt coinciding with timeout.
    do_run(0, 1'b0, 20, 1'b1, 20, 1'b0, 1'b0);
    do_run(20, 1'b0, 19, 1'b0, 20, 1'b0, 1'b0);

    // Random backpressure with a stray start during RUN.
    do_run(5, 1'b1, 4, 1'b0, 5, 1'b1, 1'b0);

    // Async reset at DMEM index 7, then a full clean sequence.
    do_run(8, 1'b0, 7, 1'b0, 8, 1'b0, 1'b1);
    do_run(3, 1'b0, 2, 1'b0, 3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
